memory_access: RTL

Pipeline MEM stage of the ARC MIPS core, directly downstream of `execute`. It registers the execute results, performs the load/store on a handshaked data-memory port and resolves the branch decision back to `fetch`. It hands a single-cycle write-back packet to the register-file write port in `decode`. While a data access is outstanding it stalls the upstream pipeline.

---
 rtl/memory_access.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// MEM pipeline stage: registers execute results, runs one handshaked data
// access at a time, resolves the branch and emits a one-cycle write-back
// packet. Upstream is stalled (o_ready low) while an access is outstanding.
//
// state  | meaning
// IDLE   | ready to accept; non-memory and faulting instructions retire next cycle
// ACCESS | data request outstanding, waiting for i_dmem_ack
module memory_access #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_con_mem_branch,
  input  logic              i_con_mem_memread,
  input  logic              i_con_mem_memwrite,
  input  logic              i_con_wb_memtoreg,
  input  logic              i_con_wb_regwrite,
  input  logic [DATA_W-1:0] i_data_AddRst,
  input  logic              i_con_Zero,
  input  logic [DATA_W-1:0] i_data_ALU_Rst,
  input  logic [DATA_W-1:0] i_data_rt,
  input  logic [REG_W-1:0]  i_addr_MuxRst,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  input  logic              i_dmem_ack,
  output logic              o_con_PCSrc,
  output logic [DATA_W-1:0] o_addr_AddRst,
  output logic              o_valid,
  output logic              o_con_wb_memtoreg,
  output logic              o_con_wb_regwrite,
  output logic [DATA_W-1:0] o_data_ReadData,
  output logic [DATA_W-1:0] o_data_ALU_Rst,
  output logic [REG_W-1:0]  o_addr_WrReg,
  output logic              o_exc
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  // EX/MEM fields needed to retire an instruction after its memory access.
  // The address and store data live in the dmem output registers.
  logic              br_q, br_d;
  logic              zero_q, zero_d;
  logic              rd_q, rd_d;
  logic              m2r_q, m2r_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;

  logic              dreq_q, dreq_d;
  logic              dwe_q, dwe_d;
  logic [DATA_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] addrst_q, addrst_d;
  logic              valid_q, valid_d;
  logic              om2r_q, om2r_d;
  logic              orw_q, orw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] oalu_q, oalu_d;
  logic [REG_W-1:0]  owreg_q, owreg_d;
  logic              exc_q, exc_d;

  logic accept, in_mem, in_fault;

  assign accept   = i_valid && (state_q == IDLE);
  assign in_mem   = i_con_mem_memread | i_con_mem_memwrite;
  // Only memory instructions care about alignment; read+write together is illegal.
  assign in_fault = (i_con_mem_memread & i_con_mem_memwrite) |
                    (in_mem & (|i_data_ALU_Rst[1:0]));

  // Next-state and output-register logic; retirement pulses default low.
  always_comb begin
    state_d  = state_q;
    br_d     = br_q;
    zero_d   = zero_q;
    rd_d     = rd_q;
    m2r_d    = m2r_q;
    rw_d     = rw_q;
    tgt_d    = tgt_q;
    wreg_d   = wreg_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    pcsrc_d  = 1'b0;
    addrst_d = addrst_q;
    valid_d  = 1'b0;
    om2r_d   = om2r_q;
    orw_d    = orw_q;
    rdata_d  = rdata_q;
    oalu_d   = oalu_q;
    owreg_d  = owreg_q;
    exc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          br_d   = i_con_mem_branch;
          zero_d = i_con_Zero;
          rd_d   = i_con_mem_memread;
          m2r_d  = i_con_wb_memtoreg;
          rw_d   = i_con_wb_regwrite;
          tgt_d  = i_data_AddRst;
          wreg_d = i_addr_MuxRst;
          if (in_mem && !in_fault) begin
            state_d  = ACCESS;
            dreq_d   = 1'b1;
            dwe_d    = i_con_mem_memwrite;
            daddr_d  = i_data_ALU_Rst;
            dwdata_d = i_data_rt;
          end else begin
            // Retire directly: plain ALU op, or a faulting access that never
            // reaches memory.
            valid_d  = 1'b1;
            om2r_d   = i_con_wb_memtoreg;
            orw_d    = i_con_wb_regwrite & ~in_fault;
            oalu_d   = i_data_ALU_Rst;
            owreg_d  = i_addr_MuxRst;
            pcsrc_d  = i_con_mem_branch & i_con_Zero & ~in_fault;
            addrst_d = i_data_AddRst;
            exc_d    = in_fault;
            rdata_d  = '0;
          end
        end
      end
      ACCESS: begin
        if (i_dmem_ack) begin
          state_d  = IDLE;
          dreq_d   = 1'b0;
          valid_d  = 1'b1;
          om2r_d   = m2r_q;
          orw_d    = rw_q;
          oalu_d   = daddr_q;
          owreg_d  = wreg_q;
          pcsrc_d  = br_q & zero_q;
          addrst_d = tgt_q;
          rdata_d  = rd_q ? i_dmem_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      br_q     <= 1'b0;
      zero_q   <= 1'b0;
      rd_q     <= 1'b0;
      m2r_q    <= 1'b0;
      rw_q     <= 1'b0;
      tgt_q    <= '0;
      wreg_q   <= '0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      pcsrc_q  <= 1'b0;
      addrst_q <= '0;
      valid_q  <= 1'b0;
      om2r_q   <= 1'b0;
      orw_q    <= 1'b0;
      rdata_q  <= '0;
      oalu_q   <= '0;
      owreg_q  <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      br_q     <= br_d;
      zero_q   <= zero_d;
      rd_q     <= rd_d;
      m2r_q    <= m2r_d;
      rw_q     <= rw_d;
      tgt_q    <= tgt_d;
      wreg_q   <= wreg_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      pcsrc_q  <= pcsrc_d;
      addrst_q <= addrst_d;
      valid_q  <= valid_d;
      om2r_q   <= om2r_d;
      orw_q    <= orw_d;
      rdata_q  <= rdata_d;
      oalu_q   <= oalu_d;
      owreg_q  <= owreg_d;
      exc_q    <= exc_d;
    end
  end

  assign o_ready           = (state_q == IDLE);
  assign o_dmem_req        = dreq_q;
  assign o_dmem_we         = dwe_q;
  assign o_dmem_addr       = daddr_q;
  assign o_dmem_wdata      = dwdata_q;
  assign o_con_PCSrc       = pcsrc_q;
  assign o_addr_AddRst     = addrst_q;
  assign o_valid           = valid_q;
  assign o_con_wb_memtoreg = om2r_q;
  assign o_con_wb_regwrite = orw_q;
  assign o_data_ReadData   = rdata_q;
  assign o_data_ALU_Rst    = oalu_q;
  assign o_addr_WrReg      = owreg_q;
  assign o_exc             = exc_q;

endmodule
